// File: rtl/etap_ir_ctrl_if.sv
// rtl/etap_ir_ctrl_if.sv - IR controller strobe/serial/decode bundle
interface etap_ir_ctrl_if #(
    parameter int IR_W    = 5,
    parameter int N_INSTR = 9,
    parameter int SEL_W   = 4
);
    logic                tdi;
    logic                capture_ir;
    logic                shift_ir;
    logic                update_ir;
    logic [IR_W-3:0]     ir_status;
    logic                tdo_ir;
    logic [IR_W-1:0]     ir_q;
    logic [SEL_W-1:0]    sel;
    logic [N_INSTR-1:0]  sel_oh;
    logic                sel_chg;

    // TAP side: drives strobes and serial input, observes decode
    modport master (
        output tdi, capture_ir, shift_ir, update_ir, ir_status,
        input  tdo_ir, ir_q, sel, sel_oh, sel_chg
    );

    // IR controller side
    modport slave (
        input  tdi, capture_ir, shift_ir, update_ir, ir_status,
        output tdo_ir, ir_q, sel, sel_oh, sel_chg
    );
endinterface

// File: rtl/etap_ir_ctrl.sv
// rtl/etap_ir_ctrl.sv - EJTAG IR shift/update stage with table-driven registered decode
module etap_ir_ctrl #(
    parameter int                         IR_W       = 5,
    parameter int                         N_INSTR    = 9,
    parameter int                         SEL_W      = 4,
    parameter logic [N_INSTR*IR_W-1:0]    OPC_TABLE  = {5'h02, 5'h1F, 5'h0C, 5'h0A, 5'h09,
                                                        5'h08, 5'h03, 5'h01, 5'h00},
    parameter logic [N_INSTR*IR_W-1:0]    MASK_TABLE = {5'h00, 5'h1F, 5'h1F, 5'h1F, 5'h1F,
                                                        5'h1F, 5'h1F, 5'h1F, 5'h1F},
    parameter int                         RESET_IDX  = 1,
    parameter int                         MISS_IDX   = 7
) (
    input  logic               tck,
    input  logic               rst,
    etap_ir_ctrl_if.slave      bus
);

    if (RESET_IDX < 0 || RESET_IDX >= N_INSTR) begin : g_bad_reset_idx
        $fatal(1, "etap_ir_ctrl: RESET_IDX out of range");
    end
    if (MISS_IDX < 0 || MISS_IDX >= N_INSTR) begin : g_bad_miss_idx
        $fatal(1, "etap_ir_ctrl: MISS_IDX out of range");
    end
    if ((1 << SEL_W) < N_INSTR) begin : g_bad_sel_w
        $fatal(1, "etap_ir_ctrl: SEL_W too narrow for N_INSTR");
    end
    if (IR_W < 2) begin : g_bad_ir_w
        $fatal(1, "etap_ir_ctrl: IR_W must be at least 2");
    end

    localparam logic [IR_W-1:0]    RST_OPC = OPC_TABLE[RESET_IDX*IR_W +: IR_W];
    localparam logic [SEL_W-1:0]   RST_SEL = SEL_W'(RESET_IDX);
    localparam logic [SEL_W-1:0]   MISS_SEL = SEL_W'(MISS_IDX);
    localparam logic [N_INSTR-1:0] ONE_OH = N_INSTR'(1);

    logic [IR_W-1:0]    sr_q, sr_d;
    logic [IR_W-1:0]    ir_q_q;
    logic [SEL_W-1:0]   sel_q;
    logic [N_INSTR-1:0] sel_oh_q;
    logic               sel_chg_q;
    logic [SEL_W-1:0]   winner;
    logic               found;

    // Shift stage next state: capture beats shift beats hold
    always_comb begin
        sr_d = sr_q;
        if (bus.capture_ir) begin
            sr_d = {bus.ir_status, 2'b01};
        end else if (bus.shift_ir) begin
            sr_d = {bus.tdi, sr_q[IR_W-1:1]};
        end
    end

    // First-match table lookup on the current shift stage, miss falls back to MISS_IDX
    always_comb begin
        winner = MISS_SEL;
        found  = 1'b0;
        for (int i = 0; i < N_INSTR; i++) begin
            if (!found &&
                (((sr_q ^ OPC_TABLE[i*IR_W +: IR_W]) & MASK_TABLE[i*IR_W +: IR_W]) == '0)) begin
                winner = SEL_W'(i);
                found  = 1'b1;
            end
        end
    end

    // Shift stage, instruction latch and registered decode; update samples the pre-edge sr
    always_ff @(posedge tck) begin
        if (rst) begin
            sr_q      <= RST_OPC;
            ir_q_q    <= RST_OPC;
            sel_q     <= RST_SEL;
            sel_oh_q  <= ONE_OH << RST_SEL;
            sel_chg_q <= 1'b0;
        end else begin
            sr_q      <= sr_d;
            sel_chg_q <= bus.update_ir && (winner != sel_q);
            if (bus.update_ir) begin
                ir_q_q   <= sr_q;
                sel_q    <= winner;
                sel_oh_q <= ONE_OH << winner;
            end
        end
    end

    assign bus.tdo_ir  = sr_q[0];
    assign bus.ir_q    = ir_q_q;
    assign bus.sel     = sel_q;
    assign bus.sel_oh  = sel_oh_q;
    assign bus.sel_chg = sel_chg_q;

endmodule
